// File: rtl/forget_sig_pkg.sv
// ---------------------------------------------------------------------------
// forget_sig_pkg
// Shared definitions for the layer-1 forget-gate sigmoid interpolator and its
// reusable arithmetic core.
//   IN_W / ADDR_W / FRAC_W : signed pre-activation width and its split into a
//                            LUT address (upper bits) and a fraction (lower).
//   DATA_W                 : signed width of LUT entries and of the result.
//   lut_entry_t            : one activation LUT entry.
//   sat_to_data()          : clamps a DATA_W+2 bit signed sum to DATA_W bits.
// ---------------------------------------------------------------------------
package forget_sig_pkg;

    localparam int IN_W   = 8;
    localparam int ADDR_W = 4;
    localparam int FRAC_W = 4;
    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] lut_entry_t;

    // The interpolation sum carries two guard bits, so anything outside the
    // DATA_W range is clamped to the nearest representable extreme.
    function automatic lut_entry_t sat_to_data(input logic signed [DATA_W+1:0] value);
        logic signed [DATA_W+1:0] max_v;
        logic signed [DATA_W+1:0] min_v;
        max_v = {3'b000, {(DATA_W-1){1'b1}}};
        min_v = {3'b111, {(DATA_W-1){1'b0}}};
        if (value > max_v) begin
            return max_v[DATA_W-1:0];
        end else if (value < min_v) begin
            return min_v[DATA_W-1:0];
        end else begin
            return value[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pwl_interp_calc.sv
// ---------------------------------------------------------------------------
// pwl_interp_calc
// Purely combinational piecewise-linear step shared by the LSTM gate paths:
//   y = sat(base + (((next - base) * frac) >>> FRAC_W))
// Ports:
//   base  (in, DATA_W, signed)  : LUT entry at the segment start
//   next  (in, DATA_W, signed)  : LUT entry at the segment end
//   frac  (in, FRAC_W, unsigned): position inside the segment
//   y     (out, DATA_W, signed) : saturated interpolated value
// ---------------------------------------------------------------------------
module pwl_interp_calc #(
    parameter int DATA_W = forget_sig_pkg::DATA_W,
    parameter int FRAC_W = forget_sig_pkg::FRAC_W
) (
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] next,
    input  logic        [FRAC_W-1:0] frac,
    output logic signed [DATA_W-1:0] y
);
    import forget_sig_pkg::*;

    localparam int PROD_W = DATA_W + FRAC_W + 2;
    localparam int SUM_W  = DATA_W + 2;

    // The saturating helper is sized by the package data width, so the core
    // must be built at that width.
    if (DATA_W != forget_sig_pkg::DATA_W) begin : g_width_check
        $error("pwl_interp_calc: DATA_W must match forget_sig_pkg::DATA_W");
    end

    logic signed [DATA_W:0]   diff;
    logic signed [FRAC_W:0]   frac_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_shift;
    logic signed [SUM_W-1:0]  sum;

    // diff needs one extra bit to hold next-base across the full signed
    // range; frac is zero-extended so the product stays a signed multiply.
    // The arithmetic shift floors toward minus infinity, and the two guard
    // bits in sum keep base + slope from wrapping before saturation.
    always_comb begin
        diff       = {next[DATA_W-1], next} - {base[DATA_W-1], base};
        frac_s     = {1'b0, frac};
        prod       = PROD_W'(diff) * PROD_W'(frac_s);
        prod_shift = prod >>> FRAC_W;
        sum        = SUM_W'(base) + SUM_W'(prod_shift);
        y          = sat_to_data(sum);
    end

endmodule

// File: rtl/forget_sig_pwl_interp.sv
// ---------------------------------------------------------------------------
// forget_sig_pwl_interp
// Three-stage pipelined piecewise-linear sigmoid for the layer-1 forget gate.
//   S1: registers the pre-activation; its upper bits address the external LUT.
//   S2: captures the LUT base/next pair and the fraction.
//   S3: registers the saturated interpolation result.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_x   : pre-activation input handshake
//   lut_address              : registered LUT read address
//   lut_base/lut_next        : combinational LUT read data for lut_address
//   out_valid/out_ready/out_y: activation output handshake
// ---------------------------------------------------------------------------
module forget_sig_pwl_interp #(
    parameter int IN_W   = forget_sig_pkg::IN_W,
    parameter int ADDR_W = forget_sig_pkg::ADDR_W,
    parameter int FRAC_W = forget_sig_pkg::FRAC_W,
    parameter int DATA_W = forget_sig_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_x,
    output logic        [ADDR_W-1:0] lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_y
);

    // The input word is split exactly into address and fraction bits.
    if (ADDR_W + FRAC_W != IN_W) begin : g_split_check
        $error("forget_sig_pwl_interp: ADDR_W + FRAC_W must equal IN_W");
    end

    logic                     stall;
    logic                     v1;
    logic                     v2;
    logic signed [IN_W-1:0]   s1_x;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [DATA_W-1:0] s2_next;
    logic        [FRAC_W-1:0] s2_frac;
    logic signed [DATA_W-1:0] calc_y;

    // The whole pipeline freezes only when a result is waiting and downstream
    // refuses it; otherwise every slot, bubble or not, moves forward.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Reading the address straight off the S1 register keeps it registered
    // and gives the LUT a full cycle before S2 samples its outputs.
    assign lut_address = s1_x[IN_W-1 -: ADDR_W];

    pwl_interp_calc #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_calc (
        .base (s2_base),
        .next (s2_next),
        .frac (s2_frac),
        .y    (calc_y)
    );

    // All three stages advance together. Reset clears every register so no
    // in-flight sample can surface afterwards; a stall holds everything,
    // which keeps out_y/out_valid and lut_address stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_x      <= '0;
            v1        <= 1'b0;
            s2_base   <= '0;
            s2_next   <= '0;
            s2_frac   <= '0;
            v2        <= 1'b0;
            out_y     <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_x      <= in_x;
            v1        <= in_valid;
            s2_base   <= lut_base;
            s2_next   <= lut_next;
            s2_frac   <= s1_x[FRAC_W-1:0];
            v2        <= v1;
            out_y     <= calc_y;
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_forget_sig_pwl_interp.sv
// ---------------------------------------------------------------------------
// tb_forget_sig_pwl_interp
// Directed and randomized bench for the forget-gate PWL interpolator. The
// bench plays the role of the parent LUT and keeps an in-order scoreboard of
// accepted samples, each tagged with how many pipeline advances it has seen.
// ---------------------------------------------------------------------------
module tb_forget_sig_pwl_interp;

    typedef struct {
        int         val;
        int         age;
        logic [7:0] x;
    } entry_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_x;
    logic        [3:0] lut_address;
    logic signed [7:0] lut_base;
    logic signed [7:0] lut_next;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_y;

    logic signed [7:0] lut [16];
    entry_t            pipe [$];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int identX [6] = '{0, 37, 111, -1, -128, -100};
    int clampX [3] = '{112, 120, 127};

    forget_sig_pwl_interp dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parent-side LUT: address 15 wraps to entry 0, address 7 clamps to itself.
    assign lut_base = lut[lut_address];
    assign lut_next = (lut_address == 4'd15) ? lut[0] :
                      (lut_address == 4'd7)  ? lut[7] : lut[lut_address + 4'd1];

    // Reference: linear blend between the two LUT entries with floor rounding,
    // clamped to the signed 8-bit range.
    function automatic int refInterp(input logic [7:0] x);
        int a, f, b, n, y;
        a = int'(x[7:4]);
        f = int'(x[3:0]);
        b = int'(lut[a]);
        if (a == 15)     n = int'(lut[0]);
        else if (a == 7) n = int'(lut[7]);
        else             n = int'(lut[a + 1]);
        y = b + (((n - b) * f) >>> 4);
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Compares the DUT's pre-edge outputs against the scoreboard view.
    task automatic checkOutput();
        logic       ov;
        logic [7:0] xs;
        ov = (pipe.size() > 0) && (pipe[0].age == 3);
        check("out_valid", 32'(out_valid), 32'(ov));
        check("in_ready", 32'(in_ready), 32'(!(ov && !out_ready)));
        if (ov) check("out_y", 32'(out_y), 32'(pipe[0].val));
        foreach (pipe[i]) begin
            if (pipe[i].age == 1) begin
                xs = pipe[i].x;
                check("lut_address", 32'(lut_address), 32'(xs[7:4]));
            end
        end
    endtask

    // Drives one cycle, checks, clocks, then advances the scoreboard.
    task automatic applyStimulus(input logic v, input logic [7:0] x, input logic rdy,
                                 input logic r, input int expY, output logic acc);
        logic   ov;
        logic   expRdy;
        entry_t e;
        in_valid  = v;
        in_x      = x;
        out_ready = rdy;
        rst       = r;
        #1;
        checkOutput();
        ov     = (pipe.size() > 0) && (pipe[0].age == 3);
        expRdy = !(ov && !rdy);
        acc    = v && expRdy && !r;
        @(posedge clk);
        if (r) begin
            pipe.delete();
        end else begin
            if (ov && rdy) e = pipe.pop_front();
            if (expRdy) begin
                foreach (pipe[i]) pipe[i].age = pipe[i].age + 1;
                if (v) begin
                    e.val = expY;
                    e.age = 1;
                    e.x   = x;
                    pipe.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic resetChecks();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_lut_address", 32'(lut_address), 32'd0);
    endtask

    task automatic drainPipe();
        logic acc;
        repeat (5) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 0, acc);
    endtask

    task automatic loadRamp();
        for (int i = 0; i < 16; i++) lut[i] = 8'(16 * i);
    endtask

    initial begin
        logic       acc;
        logic [7:0] rx;
        int         idx;
        logic       rdy;

        loadRamp();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        resetChecks();

        $display("[TB] identity region, back-to-back");
        foreach (identX[i]) applyStimulus(1'b1, 8'(identX[i]), 1'b1, 1'b0, identX[i], acc);
        drainPipe();

        $display("[TB] top clamp segment");
        foreach (clampX[i]) applyStimulus(1'b1, 8'(clampX[i]), 1'b1, 1'b0, 112, acc);
        drainPipe();

        $display("[TB] wrap segment");
        applyStimulus(1'b1, 8'(-16), 1'b1, 1'b0, -16, acc);
        applyStimulus(1'b1, 8'(-8), 1'b1, 1'b0, -8, acc);
        drainPipe();

        $display("[TB] backpressure with out_ready toggling every 2 cycles");
        idx = 0;
        for (int c = 0; c < 80 && idx < 10; c++) begin
            rdy = ((c / 2) % 2) == 1;
            rx  = 8'(idx * 26 - 120);
            applyStimulus(1'b1, rx, rdy, 1'b0, refInterp(rx), acc);
            if (acc) idx++;
        end
        if (idx < 10) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL backpressure_accept: observed %0d, expected 10", idx);
        end
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 8'd0, ((c / 2) % 2) == 1, 1'b0, 0, acc);
        drainPipe();

        $display("[TB] saturation segments");
        lut[6] = 8'sd127;
        lut[7] = -8'sd128;
        applyStimulus(1'b1, 8'h6F, 1'b1, 1'b0, -113, acc);
        drainPipe();
        lut[6] = -8'sd128;
        lut[7] = 8'sd127;
        applyStimulus(1'b1, 8'h6F, 1'b1, 1'b0, 111, acc);
        drainPipe();
        loadRamp();

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 8'd10, 1'b1, 1'b0, 10, acc);
        applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 20, acc);
        applyStimulus(1'b1, 8'd30, 1'b1, 1'b0, 30, acc);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 0, acc);
        resetChecks();
        applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 5, acc);
        drainPipe();

        $display("[TB] random stream, ramp LUT");
        for (int c = 0; c < 150; c++) begin
            rx = 8'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, rx, $urandom_range(0, 3) != 0,
                          1'b0, refInterp(rx), acc);
        end
        drainPipe();

        $display("[TB] random stream, random LUT");
        for (int i = 0; i < 16; i++) lut[i] = 8'($urandom);
        for (int c = 0; c < 150; c++) begin
            rx = 8'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, rx, $urandom_range(0, 2) != 0,
                          1'b0, refInterp(rx), acc);
        end
        drainPipe();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
